// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the DFF BIST driver.
//   state_e      : driver FSM states
//   LFSR_TAPS    : feedback taps of the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1),
//                  expressed as bit positions of a register that shifts toward bit 0
//   DEFAULT_SEED : LFSR seed used when none is supplied
//   DRAIN_CYCLES : cycles spent flushing the check pipeline after the last vector
package dff_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/dff_bist_lfsr.sv
// 16-bit Fibonacci LFSR used as the data-phase pattern source.
//   clk     : clock, posedge
//   reset   : synchronous active-high reset, loads SEED
//   load    : reload SEED (takes priority over advance)
//   advance : shift one step toward bit 0
//   bit0    : current bit 0 of the register
module dff_bist_lfsr
  import dff_bist_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic advance,
  output logic bit0
);

  logic [15:0] state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= {^(state_q & LFSR_TAPS), state_q[15:1]};
    end
  end

  assign bit0 = state_q[0];

endmodule

// File: rtl/dff_bist_driver.sv
// Stimulus-and-response engine for a single D flip-flop under test.
// Runs a reset phase (dut_rst high for RST_CYCLES), then NUM_VECTORS LFSR-driven data vectors,
// then a short drain, and reports done/pass with a saturating mismatch count.
//   clk, reset        : clock and synchronous active-high block reset
//   start             : launch request, level-sampled in idle; must drop before a relaunch
//   dut_rst, dut_d    : registered drive to the DFF under test
//   dut_q, dut_qbar   : DFF outputs
//   busy, done, pass  : status
//   err_count         : saturating count of failed checks
// Build option: define DFF_BIST_QBAR_CHECK_EN to also check dut_qbar in every check;
// otherwise dut_qbar is ignored.
module dff_bist_driver
  import dff_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned ERR_W       = 8,
  parameter logic [15:0] SEED        = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_rst,
  output logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CntMaxA = (NUM_VECTORS > RST_CYCLES) ? NUM_VECTORS : RST_CYCLES;
  localparam int unsigned CntMax  = (CntMaxA > DRAIN_CYCLES) ? CntMaxA : DRAIN_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast   = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] NumVec    = CntW'(NUM_VECTORS);
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  // Drive-cycle flags, registered alongside dut_rst/dut_d, then delayed once more so they line
  // up with the cycle in which the DFF output reflects that drive.
  logic rv_drv_q, dv_drv_q;
  logic rv_q, dv_q;
  logic d_dly;

  logic lfsr_load, lfsr_adv, lfsr_bit;
  logic rst_fail, run_fail;

  assign lfsr_load = (state_q == StIdle) && start;
  // The last reset-phase edge already drives the first vector, so it consumes an LFSR step.
  assign lfsr_adv  = ((state_q == StRst) && (cnt_q == RstLast)) ||
                     ((state_q == StRun) && (cnt_q != NumVec));

  dff_bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .bit0    (lfsr_bit)
  );

  // cnt_q counts reset cycles in StRst, vectors already driven in StRun, drain cycles in StDrain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dut_rst  <= 1'b0;
      dut_d    <= 1'b0;
      rv_drv_q <= 1'b0;
      dv_drv_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRst;
            cnt_q    <= '0;
            dut_rst  <= 1'b1;
            dut_d    <= 1'b0;
            rv_drv_q <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StRst: begin
          if (cnt_q == RstLast) begin
            state_q  <= StRun;
            cnt_q    <= CntW'(1);
            dut_rst  <= 1'b0;
            dut_d    <= lfsr_bit;
            rv_drv_q <= 1'b0;
            dv_drv_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (cnt_q == NumVec) begin
            state_q  <= StDrain;
            cnt_q    <= '0;
            dut_d    <= 1'b0;
            dv_drv_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            dut_d <= lfsr_bit;
          end
        end
        StDrain: begin
          if (cnt_q == DrainLast) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          // Level-sensitive release: a start still held high never relaunches.
          if (!start) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DFF_BIST_QBAR_CHECK_EN
  assign rst_fail = rv_q && ((dut_q != 1'b0) || (dut_qbar != 1'b1));
  assign run_fail = dv_q && ((dut_q != d_dly) || (dut_qbar != ~d_dly));
`else
  logic unused_qbar;
  assign unused_qbar = dut_qbar;
  assign rst_fail    = rv_q && (dut_q != 1'b0);
  assign run_fail    = dv_q && (dut_q != d_dly);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rv_q      <= 1'b0;
      dv_q      <= 1'b0;
      d_dly     <= 1'b0;
      err_count <= '0;
    end else begin
      rv_q  <= rv_drv_q;
      dv_q  <= dv_drv_q;
      d_dly <= dut_d;
      if (lfsr_load) begin
        err_count <= '0;
      end else if ((rst_fail || run_fail) && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_dff_bist_driver.sv
// Directed self-checking bench for dff_bist_driver: a behavioural DFF model with selectable
// faults, plus a second narrow-counter instance for saturation.
module tb_dff_bist_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dut_rst, dut_d, dut_q, dut_qbar;
  logic       busy, done, pass;
  logic [7:0] err_count;

  logic       start2 = 1'b0;
  logic       dut_rst2, dut_d2, dut_q2, dut_qbar2;
  logic       busy2, done2, pass2;
  logic [3:0] err_count2;

  // 0 ideal, 1 q forced high while in reset, 3 qbar stuck at 0
  int         mode = 0;
  logic       q_r, q2_r;

  int n_total = 0;
  int n_pass = 0;
  int done_edge;
  bit seq_d   [600];
  bit seq_rst [600];
  bit first_d [600];

  always #5 clk = ~clk;

  dff_bist_driver dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dut_rst   (dut_rst),
    .dut_d     (dut_d),
    .dut_q     (dut_q),
    .dut_qbar  (dut_qbar),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
  );

  dff_bist_driver #(
    .ERR_W (4)
  ) dut_w4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .dut_rst   (dut_rst2),
    .dut_d     (dut_d2),
    .dut_q     (dut_q2),
    .dut_qbar  (dut_qbar2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err_count2)
  );

  // DFF models with synchronous reset.
  always @(posedge clk) begin
    if (dut_rst) q_r <= (mode == 1);
    else         q_r <= dut_d;
  end
  assign dut_q    = q_r;
  assign dut_qbar = (mode == 3) ? 1'b0 : ~q_r;

  always @(posedge clk) begin
    if (dut_rst2) q2_r <= 1'b0;
    else          q2_r <= dut_d2;
  end
  assign dut_q2    = ~q2_r;
  assign dut_qbar2 = q2_r;

  // Bit 0 of the seed-0xACE1 Fibonacci LFSR after idx shifts.
  function automatic bit vec_bit(input int idx);
    logic [15:0] s;
    logic fb;
    s = 16'hACE1;
    for (int i = 0; i < idx; i++) begin
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      s  = {fb, s[15:1]};
    end
    return s[0];
  endfunction

  // One idle edge (releases DONE if start was low), then a start request; records the drive
  // after each edge (edge 1 samples start) until done or the budget expires.
  task automatic launch(input bit hold);
    done_edge = 0;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    seq_d[1]   = dut_d;
    seq_rst[1] = dut_rst;
    if (!hold) start = 1'b0;
    for (int e = 2; e < 600; e++) begin
      @(posedge clk); #1;
      seq_d[e]   = dut_d;
      seq_rst[e] = dut_rst;
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({dut_rst, dut_d, busy, done, pass} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {dut_rst, dut_d, busy, done, pass});
    else n_pass++;
    n_total++;
    if (err_count !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_count);
    else n_pass++;
    n_total++;
    if (err_count2 !== 4'd0) $display("FAIL reset_err_w4: got %0d want 0", err_count2);
    else n_pass++;
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_no_launch: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_ideal();
    int bad;
    mode = 0;
    launch(1'b0);
    n_total++;
    if (done_edge !== 261) $display("FAIL ideal_done_edge: got %0d want 261", done_edge);
    else n_pass++;
    n_total++;
    if ({seq_rst[1], seq_rst[2], seq_rst[3]} !== 3'b110)
      $display("FAIL ideal_dut_rst: got %b want 110", {seq_rst[1], seq_rst[2], seq_rst[3]});
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 256; i++) if (seq_d[i + 3] !== vec_bit(i)) bad++;
    if (seq_d[259] !== 1'b0) bad++;
    n_total++;
    if (bad !== 0) $display("FAIL ideal_d_seq: got %0d wrong vectors want 0", bad);
    else n_pass++;
    n_total++;
    if ({err_count, pass, busy} !== {8'd0, 1'b1, 1'b0})
      $display("FAIL ideal_result: got err=%0d pass=%b busy=%b want err=0 pass=1 busy=0",
               err_count, pass, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0) $display("FAIL ideal_release: done got %b want 0", done);
    else n_pass++;
  endtask

  task automatic test_rst_fault();
    mode = 1;
    launch(1'b0);
    n_total++;
    if ({err_count, pass} !== {8'd2, 1'b0})
      $display("FAIL rst_fault: got err=%0d pass=%b want err=2 pass=0", err_count, pass);
    else n_pass++;
    mode = 0;
  endtask

  task automatic test_qbar_stuck();
    int exp_err;
    int zeros;
    zeros = 0;
    for (int i = 0; i < 256; i++) if (vec_bit(i) == 1'b0) zeros++;
`ifdef DFF_BIST_QBAR_CHECK_EN
    exp_err = 2 + zeros;
    if (exp_err > 255) exp_err = 255;
`else
    exp_err = 0;
`endif
    mode = 3;
    launch(1'b0);
    n_total++;
    if (err_count !== exp_err[7:0])
      $display("FAIL qbar_stuck_err: got %0d want %0d", err_count, exp_err);
    else n_pass++;
    n_total++;
    if (pass !== (exp_err == 0)) $display("FAIL qbar_stuck_pass: got %b want %b", pass, exp_err == 0);
    else n_pass++;
    mode = 0;
  endtask

  task automatic test_saturate();
    int e2;
    e2 = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int e = 2; e < 600; e++) begin
      @(posedge clk); #1;
      if (e == 150) begin
        n_total++;
        if (err_count2 !== 4'd15) $display("FAIL sat_mid: got %0d want 15", err_count2);
        else n_pass++;
      end
      if (done2) begin
        e2 = e;
        break;
      end
    end
    n_total++;
    if (e2 !== 261) $display("FAIL sat_done_edge: got %0d want 261", e2);
    else n_pass++;
    n_total++;
    if ({err_count2, pass2} !== {4'd15, 1'b0})
      $display("FAIL sat_result: got err=%0d pass=%b want err=15 pass=0", err_count2, pass2);
    else n_pass++;
  endtask

  task automatic test_abort();
    mode = 1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (101) @(posedge clk);
    #1;
    // Edge 102 has just driven vector 100; two faulty reset checks already counted.
    n_total++;
    if ({dut_d, busy, err_count} !== {vec_bit(99), 1'b1, 8'd2})
      $display("FAIL abort_pre: got d=%b busy=%b err=%0d want d=%b busy=1 err=2",
               dut_d, busy, err_count, vec_bit(99));
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({dut_rst, dut_d, busy, done, pass, err_count} !== 13'd0)
      $display("FAIL abort_reset: got rst=%b d=%b busy=%b done=%b pass=%b err=%0d want all 0",
               dut_rst, dut_d, busy, done, pass, err_count);
    else n_pass++;
    reset = 1'b0;
    mode = 0;
    launch(1'b0);
    n_total++;
    if ({done_edge == 261, err_count, pass} !== {1'b1, 8'd0, 1'b1})
      $display("FAIL abort_rerun: got edge=%0d err=%0d pass=%b want edge=261 err=0 pass=1",
               done_edge, err_count, pass);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    mode = 0;
    launch(1'b1);
    for (int e = 0; e < 600; e++) first_d[e] = seq_d[e];
    n_total++;
    if (done_edge !== 261) $display("FAIL b2b_first_edge: got %0d want 261", done_edge);
    else n_pass++;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL b2b_hold: got %0d cycles not parked in done want 0", bad);
    else n_pass++;
    start = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0) $display("FAIL b2b_release: done got %b want 0", done);
    else n_pass++;
    launch(1'b0);
    bad = 0;
    for (int e = 1; e < 262; e++) if (seq_d[e] !== first_d[e]) bad++;
    n_total++;
    if (done_edge !== 261 || bad !== 0)
      $display("FAIL b2b_rerun: got edge=%0d diffs=%0d want edge=261 diffs=0", done_edge, bad);
    else n_pass++;
    n_total++;
    if ({err_count, pass} !== {8'd0, 1'b1})
      $display("FAIL b2b_result: got err=%0d pass=%b want err=0 pass=1", err_count, pass);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_rst_fault();
    test_qbar_stuck();
    test_saturate();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
